sdram_sched: RTL and testbench
==============================

# sdram_sched

Power-up initialiser and refresh scheduler for the card's SDRAM command bus. After reset it runs the JEDEC init sequence: wait, PRECHARGE ALL, auto-refreshes, LOAD MODE. It then issues auto-refresh on a fixed interval using a debt counter. Refreshes are slotted between Apple-bus access windows, and command-bus ownership is handed to the access sequencer through a request/grant handshake.

## Interface
- INIT_WAIT, 2500: cycles of NOP after reset before PRECHARGE ALL (100 µs at 25 MHz).
- INIT_REFS, 8: auto-refreshes issued during init.
- REF_INTERVAL, 195: cycles between refresh ticks (7.8 µs at 25 MHz).
- MAX_DEBT, 8: refresh-debt saturation level; 4-bit counter.
- TRP, 1: NOP cycles after PRECHARGE ALL.
- TRFC, 2: NOP cycles after each AREF.
- TMRD, 2: NOP cycles after LOAD MODE.
- MODE, 13'h020: mode register value (CL2, sequential, burst 1).

Ports:
- C25M  in  1  system clock (25 MHz), all logic on posedge.
- RES  in  1  reset, asynchronous, active-high.
- BusReq  in  1  access sequencer requests command bus.
- BusDone  in  1  access sequencer releases command bus.
- BusGnt  out  1  command bus granted to access sequencer.
- Ready  out  1  init complete.
- CmdOE  out  1  this block drives the command bus outputs below.
- RCKE, nRCS, nRAS, nCAS, nSWE  out  1 each  SDRAM control.
- SBA  out  2  bank address.
- SA  out  13  row/mode address.
- Overrun  out  1  sticky: a tick occurred while debt was at MAX_DEBT.

## Operation
- Reset values: BusGnt=0, Ready=0, CmdOE=1, RCKE=0, nRCS=nRAS=nCAS=nSWE=1, SBA=0, SA=0, Overrun=0, debt=0, state=INIT_WAIT, counters=0.
- All outputs are registered. Command encodings (nRCS,nRAS,nCAS,nSWE):
  - NOP: 1,1,1,1.
  - PRECHARGE ALL: 0,0,1,0 with SA[10]=1.
  - AREF: 0,0,0,1.
  - LOAD MODE: 0,0,0,0 with SBA=0, SA=MODE.
- Init states:
  - INIT_WAIT: NOP, RCKE=1, for INIT_WAIT cycles.
  - PC, then TRP NOPs.
  - INIT_REF: AREF then TRFC NOPs, repeated INIT_REFS times.
  - MRS, then TMRD NOPs.
  - IDLE: Ready=1, set on entry and held until reset.
- BusReq and the refresh timer are ignored until Ready.
- Refresh timer: counts 0..REF_INTERVAL-1 and wraps; the wrap cycle is the tick. Timer starts on entry to IDLE.
- Debt update per cycle: +1 on tick, -1 on AREF issue. Both in the same cycle leaves debt unchanged. Debt saturates at MAX_DEBT; a tick at saturation sets Overrun.
- IDLE arbitration, evaluated every cycle:
  - If BusReq and debt<MAX_DEBT: go to BUS.
  - Else if debt>0: issue AREF and go to REF_WAIT (TRFC NOPs), then return to IDLE.
  - Else: NOP.
- BUS state: BusGnt=1 and CmdOE=0 (the sequencer drives the command bus). Stays in BUS until BusDone is sampled high. Next cycle: BusGnt=0, CmdOE=1, back to IDLE.
- BusReq at saturated debt: the grant is withheld until one AREF plus its TRFC completes.
- BusDone outside BUS is ignored.

## Timing
- BusReq sampled high in IDLE (debt<MAX_DEBT): BusGnt=1 on the next edge (1-cycle latency).
- Worst-case grant latency while Ready: 1+TRFC+1 cycles (request arrives during REF_WAIT at saturation).
- BusDone high at edge N: BusGnt=0 at edge N+1. The earliest AREF or new grant is at edge N+2.
- AREF to any next command: at least TRFC+1 cycles. PC to AREF: TRP+1. MRS to Ready: TMRD+1.
- Ready rises exactly INIT_WAIT+1+TRP+INIT_REFS*(1+TRFC)+1+TMRD cycles after reset release.
- RES asserted mid-operation (including BUS): all outputs immediately go to reset values, BusGnt drops asynchronously, and init restarts on release.
- In the first cycle after IDLE entry, the tick is not asserted.

## Test plan
- Reset release, no BusReq: check the PC, 8 AREF, MRS(SA=0x020) order and spacing. With defaults, Ready=1 at cycle 2500+1+1+24+1+2=2529.
- Ready, debt=0, BusReq pulse, BusDone 5 cycles after grant: BusGnt high 1 cycle after request, CmdOE=0 for the whole window, no AREF inside the window.
- Ready, BusReq held continuously with BusDone after 1 cycle, run 8×195 cycles: debt reaches 8. The next request is held off until an AREF, and BusGnt is re-granted 1+TRFC+1 cycles later.
- Hold BusGnt (no BusDone) for 9×195 cycles: Overrun=1 and debt=8. After BusDone, exactly 8 AREFs are issued back-to-back at TRFC+1 spacing.
- AREF issued on the same cycle as a tick: debt is unchanged.
- Assert RES during BUS and during INIT_REF: BusGnt/Ready=0 and RCKE=0 immediately; after release the full init is re-observed.

Source files
------------

// File: rtl/sdram_sched.sv
// SDRAM power-up initialiser and auto-refresh scheduler.
// Arbitrates the command bus between refresh debt and the access sequencer.
module sdram_sched #(
    parameter int         INIT_WAIT    = 2500,
    parameter int         INIT_REFS    = 8,
    parameter int         REF_INTERVAL = 195,
    parameter int         MAX_DEBT     = 8,
    parameter int         TRP          = 1,
    parameter int         TRFC         = 2,
    parameter int         TMRD         = 2,
    parameter logic [12:0] MODE        = 13'h020
) (
    input  logic        C25M,
    input  logic        RES,
    input  logic        BusReq,
    input  logic        BusDone,
    output logic        BusGnt,
    output logic        Ready,
    output logic        CmdOE,
    output logic        RCKE,
    output logic        nRCS,
    output logic        nRAS,
    output logic        nCAS,
    output logic        nSWE,
    output logic [1:0]  SBA,
    output logic [12:0] SA,
    output logic        Overrun
);

    localparam int CW = $clog2(INIT_WAIT + 1);
    localparam int RW = $clog2(INIT_REFS + 1);
    localparam int TW = $clog2(REF_INTERVAL);

    localparam logic [3:0] CMD_NOP = 4'b1111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [3:0] DMAX = 4'(MAX_DEBT);

    typedef enum logic [2:0] {
        sWait,
        sPre,
        sIref,
        sMrs,
        sIdle,
        sRefw,
        sBus
    } stateT;

    stateT         state;
    stateT         stateNxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNxt;
    logic [RW-1:0] refCnt;
    logic [RW-1:0] refCntNxt;
    logic [TW-1:0] timer;
    logic [3:0]    debt;

    logic [3:0]    cmdNxt;
    logic [12:0]   saNxt;
    logic          gntNxt;
    logic          oeNxt;
    logic          readyNxt;
    logic          arefNow;
    logic          tick;

    assign tick = Ready && (timer == TW'(REF_INTERVAL - 1));

    // Each command is emitted on the edge that enters its state; the state
    // then counts its trailing NOPs and emits the following command itself.
    always_comb begin
        stateNxt  = state;
        cntNxt    = cnt;
        refCntNxt = refCnt;
        cmdNxt    = CMD_NOP;
        saNxt     = '0;
        gntNxt    = 1'b0;
        oeNxt     = 1'b1;
        readyNxt  = Ready;
        arefNow   = 1'b0;
        unique case (state)
            sWait: begin
                if (cnt == CW'(INIT_WAIT - 1)) begin
                    stateNxt = sPre;
                    cntNxt   = '0;
                    cmdNxt   = CMD_PRE;
                    saNxt    = 13'h0400;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            sPre: begin
                if (cnt == CW'(TRP)) begin
                    stateNxt  = sIref;
                    cntNxt    = '0;
                    cmdNxt    = CMD_REF;
                    refCntNxt = RW'(1);
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            sIref: begin
                if (cnt == CW'(TRFC)) begin
                    cntNxt = '0;
                    if (refCnt == RW'(INIT_REFS)) begin
                        stateNxt = sMrs;
                        cmdNxt   = CMD_MRS;
                        saNxt    = MODE;
                    end else begin
                        cmdNxt    = CMD_REF;
                        refCntNxt = refCnt + 1'b1;
                    end
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            sMrs: begin
                if (cnt == CW'(TMRD)) begin
                    stateNxt = sIdle;
                    cntNxt   = '0;
                    readyNxt = 1'b1;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            sIdle: begin
                // The sequencer wins unless debt is saturated.
                if (BusReq && (debt < DMAX)) begin
                    stateNxt = sBus;
                    gntNxt   = 1'b1;
                    oeNxt    = 1'b0;
                end else if (debt != 4'd0) begin
                    stateNxt = sRefw;
                    cntNxt   = '0;
                    cmdNxt   = CMD_REF;
                    arefNow  = 1'b1;
                end
            end
            sRefw: begin
                if (cnt == CW'(TRFC - 1)) begin
                    stateNxt = sIdle;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            sBus: begin
                if (BusDone) begin
                    stateNxt = sIdle;
                end else begin
                    gntNxt = 1'b1;
                    oeNxt  = 1'b0;
                end
            end
            default: begin
                stateNxt = sWait;
                cntNxt   = '0;
            end
        endcase
    end

    always_ff @(posedge C25M or posedge RES) begin
        if (RES) begin
            state   <= sWait;
            cnt     <= '0;
            refCnt  <= '0;
            BusGnt  <= 1'b0;
            Ready   <= 1'b0;
            CmdOE   <= 1'b1;
            RCKE    <= 1'b0;
            nRCS    <= 1'b1;
            nRAS    <= 1'b1;
            nCAS    <= 1'b1;
            nSWE    <= 1'b1;
            SBA     <= 2'b00;
            SA      <= '0;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            refCnt  <= refCntNxt;
            BusGnt  <= gntNxt;
            Ready   <= readyNxt;
            CmdOE   <= oeNxt;
            RCKE    <= 1'b1;
            {nRCS, nRAS, nCAS, nSWE} <= cmdNxt;
            SBA     <= 2'b00;
            SA      <= saNxt;
        end
    end

    // Timer only runs once init is done, so its first wrap lands
    // REF_INTERVAL cycles after IDLE entry.
    always_ff @(posedge C25M or posedge RES) begin
        if (RES) begin
            timer   <= '0;
            debt    <= 4'd0;
            Overrun <= 1'b0;
        end else begin
            if (!Ready || tick) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            unique case ({tick, arefNow})
                2'b10: begin
                    if (debt == DMAX) begin
                        Overrun <= 1'b1;
                    end else begin
                        debt <= debt + 4'd1;
                    end
                end
                2'b01:   debt <= debt - 4'd1;
                default: debt <= debt;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: init sequence, bus handshake,
// refresh debt, overrun and asynchronous reset.
module tb_sdram_sched;

    localparam logic [3:0] NOP = 4'b1111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

    logic        C25M = 1'b0;
    logic        RES = 1'b1;
    logic        BusReq = 1'b0;
    logic        BusDone = 1'b0;
    logic        BusGnt;
    logic        Ready;
    logic        CmdOE;
    logic        RCKE;
    logic        nRCS;
    logic        nRAS;
    logic        nCAS;
    logic        nSWE;
    logic [1:0]  SBA;
    logic [12:0] SA;
    logic        Overrun;
    logic [3:0]  cmd;

    int nChk = 0;
    int nFail = 0;
    int t = 0;

    assign cmd = {nRCS, nRAS, nCAS, nSWE};

    sdram_sched dut (
        .C25M    (C25M),
        .RES     (RES),
        .BusReq  (BusReq),
        .BusDone (BusDone),
        .BusGnt  (BusGnt),
        .Ready   (Ready),
        .CmdOE   (CmdOE),
        .RCKE    (RCKE),
        .nRCS    (nRCS),
        .nRAS    (nRAS),
        .nCAS    (nCAS),
        .nSWE    (nSWE),
        .SBA     (SBA),
        .SA      (SA),
        .Overrun (Overrun)
    );

    always #5 C25M = ~C25M;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge C25M);
        #1;
        t++;
    endtask

    task automatic runTo(input int target);
        while (t < target) step();
    endtask

    task automatic checkReset(input string tag);
        checkVal($sformatf("%s_ctl", tag),
                 {23'd0, BusGnt, Ready, CmdOE, RCKE, cmd, Overrun},
                 {23'd0, 1'b0, 1'b0, 1'b1, 1'b0, NOP, 1'b0});
        checkVal($sformatf("%s_addr", tag), {17'd0, SBA, SA}, 32'd0);
    endtask

    // Releases reset and checks command order, spacing and Ready timing.
    task automatic runInit(input string tag);
        int          evE[$];
        logic [18:0] evC[$];
        int          rdy;
        int          gotE;
        int          expE;
        logic [18:0] gotC;
        logic [18:0] expC;
        @(posedge C25M);
        #1;
        RES = 1'b0;
        rdy = 0;
        for (int e = 1; e <= 2600 && rdy == 0; e++) begin
            @(posedge C25M);
            #1;
            if (e == 1)
                checkVal($sformatf("%s_e1", tag), {26'd0, RCKE, Ready, cmd},
                         {26'd0, 1'b1, 1'b0, NOP});
            if (cmd != NOP) begin
                evE.push_back(e);
                evC.push_back({cmd, SBA, SA});
            end
            if (Ready) rdy = e;
        end
        checkVal($sformatf("%s_ready", tag), rdy, 2529);
        checkVal($sformatf("%s_ncmd", tag), evE.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                expE = 2500;
                expC = {PRE, 2'b00, 13'h0400};
            end else if (i == 9) begin
                expE = 2526;
                expC = {MRS, 2'b00, 13'h0020};
            end else begin
                expE = 2502 + 3 * (i - 1);
                expC = {REF, 2'b00, 13'h0000};
            end
            gotE = -1;
            gotC = '1;
            if (i < evE.size()) begin
                gotE = evE[i];
                gotC = evC[i];
            end
            checkVal($sformatf("%s_at%0d", tag, i), gotE, expE);
            checkVal($sformatf("%s_cmd%0d", tag, i), {13'd0, gotC}, {13'd0, expC});
        end
        t = 0;
    endtask

    initial begin
        int bad;
        int arefE[$];
        int gotE;

        repeat (3) @(posedge C25M);
        #1;
        checkReset("rst0");
        runInit("init0");

        BusReq = 1'b1;
        step();
        checkVal("gnt_lat", {30'd0, BusGnt, CmdOE}, {30'd0, 2'b10});
        BusReq = 1'b0;
        bad = 0;
        repeat (4) begin
            step();
            if (!(BusGnt && !CmdOE && cmd == NOP)) bad++;
        end
        checkVal("bus_win", bad, 0);
        BusDone = 1'b1;
        step();
        checkVal("bus_rel", {30'd0, BusGnt, CmdOE}, {30'd0, 2'b01});
        BusDone = 1'b0;

        runTo(8);
        BusDone = 1'b1;
        step();
        checkVal("done_idle", {26'd0, BusGnt, CmdOE, cmd},
                 {26'd0, 1'b0, 1'b1, NOP});
        BusDone = 1'b0;

        runTo(195);
        checkVal("tick1_debt", {24'd0, dut.debt, cmd}, {24'd0, 4'd1, NOP});
        step();
        checkVal("tick1_aref", {24'd0, dut.debt, cmd}, {24'd0, 4'd0, REF});

        runTo(300);
        BusReq = 1'b1;
        step();
        checkVal("gnt2", {31'd0, BusGnt}, 32'd1);
        BusReq = 1'b0;
        runTo(583);
        BusDone = 1'b1;
        step();
        checkVal("rel2", {27'd0, BusGnt, dut.debt}, {27'd0, 1'b0, 4'd1});
        BusDone = 1'b0;
        step();
        checkVal("tick_aref", {24'd0, cmd, dut.debt}, {24'd0, REF, 4'd1});
        runTo(588);
        checkVal("aref2", {24'd0, cmd, dut.debt}, {24'd0, REF, 4'd0});

        runTo(600);
        BusReq = 1'b1;
        BusDone = 1'b1;
        runTo(2145);
        checkVal("sat_debt", {27'd0, BusGnt, dut.debt}, {27'd0, 1'b1, 4'd8});
        step();
        step();
        checkVal("sat_aref", {23'd0, BusGnt, cmd, dut.debt},
                 {23'd0, 1'b0, REF, 4'd7});
        bad = 0;
        repeat (2) begin
            step();
            if (BusGnt) bad++;
        end
        checkVal("sat_hold", bad, 0);
        step();
        checkVal("sat_regnt", {31'd0, BusGnt}, 32'd1);
        BusReq = 1'b0;
        step();
        BusDone = 1'b0;

        runTo(2200);
        checkVal("drain", {28'd0, dut.debt}, 32'd0);
        BusReq = 1'b1;
        step();
        BusReq = 1'b0;
        runTo(3899);
        checkVal("pre_ovr", {26'd0, Overrun, dut.debt, BusGnt},
                 {26'd0, 1'b0, 4'd8, 1'b1});
        step();
        checkVal("ovr", {27'd0, Overrun, dut.debt}, {27'd0, 1'b1, 4'd8});
        runTo(3905);
        BusDone = 1'b1;
        step();
        checkVal("ovr_rel", {31'd0, BusGnt}, 32'd0);
        BusDone = 1'b0;
        while (t < 3990) begin
            step();
            if (cmd == REF) arefE.push_back(t);
        end
        checkVal("ovr_nref", arefE.size(), 8);
        for (int i = 0; i < 8; i++) begin
            gotE = -1;
            if (i < arefE.size()) gotE = arefE[i];
            checkVal($sformatf("ovr_ref%0d", i), gotE, 3907 + 3 * i);
        end
        checkVal("ovr_sticky", {27'd0, Overrun, dut.debt}, {27'd0, 1'b1, 4'd0});

        runTo(4010);
        BusReq = 1'b1;
        step();
        checkVal("gnt4", {31'd0, BusGnt}, 32'd1);
        BusReq = 1'b0;
        #3;
        RES = 1'b1;
        #1;
        checkReset("rst_bus");
        runInit("init1");

        #3;
        RES = 1'b1;
        @(posedge C25M);
        #1;
        RES = 1'b0;
        repeat (2508) @(posedge C25M);
        #1;
        checkVal("pre_iref", {28'd0, cmd}, {28'd0, REF});
        repeat (2) @(posedge C25M);
        #3;
        RES = 1'b1;
        #1;
        checkReset("rst_iref");
        runInit("init2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end

endmodule
